// File: rtl/time_pkg.sv
// Shared widths, default terminal values and alarm state encoding for the
// time-of-day keeper and its field counters.
package time_pkg;

    localparam int HH_W = 5;
    localparam int MM_W = 6;
    localparam int SS_W = 6;

    localparam int SEC_MAX_DEF  = 59;
    localparam int MIN_MAX_DEF  = 59;
    localparam int HOUR_MAX_DEF = 23;

    typedef enum logic {
        IDLE    = 1'b0,
        RINGING = 1'b1
    } alarm_state_t;

    // A load is accepted only when every field is within its terminal value.
    function automatic logic fields_in_range(
        input logic [HH_W-1:0] hh,
        input logic [MM_W-1:0] mm,
        input logic [SS_W-1:0] ss,
        input int              hour_max,
        input int              min_max,
        input int              sec_max
    );
        return (32'(hh) <= 32'(hour_max)) &&
               (32'(mm) <= 32'(min_max))  &&
               (32'(ss) <= 32'(sec_max));
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// One time-of-day field: loadable modulo-(MAX+1) counter whose combinational
// wrap output carries into the next, slower field.
module wrap_counter #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    // A load suppresses both the increment and the carry out of this field.
    assign wrap = inc && !load && (value == MAX_V);

    // Field register: load has priority over increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value <= {WIDTH{1'b0}};
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= wrap ? {WIDTH{1'b0}} : value + WIDTH'(1'b1);
        end else begin
            value <= value;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// 24-hour hh:mm:ss keeper driven by a once-per-second pulse, with validated
// synchronous load, registered rollover ticks and a latched, acknowledgeable alarm.
module time_keeper
    import time_pkg::*;
#(
    parameter int SEC_MAX  = SEC_MAX_DEF,
    parameter int MIN_MAX  = MIN_MAX_DEF,
    parameter int HOUR_MAX = HOUR_MAX_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_sec_tick,
    input  logic            io_load,
    input  logic [HH_W-1:0] io_load_hh,
    input  logic [MM_W-1:0] io_load_mm,
    input  logic [SS_W-1:0] io_load_ss,
    input  logic            io_alarm_en,
    input  logic [HH_W-1:0] io_alarm_hh,
    input  logic [MM_W-1:0] io_alarm_mm,
    input  logic            io_alarm_ack,
    output logic [HH_W-1:0] io_hh,
    output logic [MM_W-1:0] io_mm,
    output logic [SS_W-1:0] io_ss,
    output logic            io_min_tick,
    output logic            io_hour_tick,
    output logic            io_day_tick,
    output logic            io_load_err,
    output logic            io_alarm
);

    logic            range_ok_s;
    logic            load_ok_s;
    logic            load_bad_s;
    logic            ss_inc_s;
    logic            ss_wrap_s;
    logic            mm_wrap_s;
    logic            hh_wrap_s;
    logic [MM_W-1:0] mm_next_s;
    logic [HH_W-1:0] hh_next_s;
    logic            match_s;
    alarm_state_t    state_r;
    logic            alarm_r;

    assign range_ok_s = fields_in_range(io_load_hh, io_load_mm, io_load_ss,
                                        HOUR_MAX, MIN_MAX, SEC_MAX);
    assign load_ok_s  = io_load && range_ok_s;
    assign load_bad_s = io_load && !range_ok_s;
    // A rejected load leaves the coincident second tick in force.
    assign ss_inc_s   = io_sec_tick && !load_ok_s;

    wrap_counter #(.WIDTH(SS_W), .MAX(SEC_MAX)) u_ss (
        .clock    (clock),
        .reset    (reset),
        .inc      (ss_inc_s),
        .load     (load_ok_s),
        .load_val (io_load_ss),
        .value    (io_ss),
        .wrap     (ss_wrap_s)
    );

    wrap_counter #(.WIDTH(MM_W), .MAX(MIN_MAX)) u_mm (
        .clock    (clock),
        .reset    (reset),
        .inc      (ss_wrap_s),
        .load     (load_ok_s),
        .load_val (io_load_mm),
        .value    (io_mm),
        .wrap     (mm_wrap_s)
    );

    wrap_counter #(.WIDTH(HH_W), .MAX(HOUR_MAX)) u_hh (
        .clock    (clock),
        .reset    (reset),
        .inc      (mm_wrap_s),
        .load     (load_ok_s),
        .load_val (io_load_hh),
        .value    (io_hh),
        .wrap     (hh_wrap_s)
    );

    // Tick-driven next hh:mm; ss is 0 exactly when the seconds field wraps.
    always_comb begin
        mm_next_s = io_mm;
        hh_next_s = io_hh;
        if (mm_wrap_s) begin
            mm_next_s = {MM_W{1'b0}};
        end else if (ss_wrap_s) begin
            mm_next_s = io_mm + 6'd1;
        end else begin
            mm_next_s = io_mm;
        end
        if (hh_wrap_s) begin
            hh_next_s = {HH_W{1'b0}};
        end else if (mm_wrap_s) begin
            hh_next_s = io_hh + 5'd1;
        end else begin
            hh_next_s = io_hh;
        end
    end

    assign match_s = io_alarm_en && ss_wrap_s &&
                     (hh_next_s == io_alarm_hh) && (mm_next_s == io_alarm_mm);

    // Rollover and load-error pulses, one cycle each.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_min_tick  <= 1'b0;
            io_hour_tick <= 1'b0;
            io_day_tick  <= 1'b0;
            io_load_err  <= 1'b0;
        end else begin
            io_min_tick  <= ss_wrap_s;
            io_hour_tick <= mm_wrap_s;
            io_day_tick  <= hh_wrap_s;
            io_load_err  <= load_bad_s;
        end
    end

    // Alarm FSM; a fresh match outranks an acknowledge in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            alarm_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (match_s) begin
                        state_r <= RINGING;
                        alarm_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        alarm_r <= 1'b0;
                    end
                end
                RINGING: begin
                    if (match_s) begin
                        state_r <= RINGING;
                        alarm_r <= 1'b1;
                    end else if (io_alarm_ack || !io_alarm_en) begin
                        state_r <= IDLE;
                        alarm_r <= 1'b0;
                    end else begin
                        state_r <= RINGING;
                        alarm_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    alarm_r <= 1'b0;
                end
            endcase
        end
    end

    assign io_alarm = alarm_r;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: a cycle-by-cycle vector table plus
// hand-written sequences for the minute carry and asynchronous reset.
module tb_time_keeper;

    logic       clock = 1'b0;
    logic       reset;
    logic       io_sec_tick, io_load, io_alarm_en, io_alarm_ack;
    logic [4:0] io_load_hh, io_alarm_hh, io_hh;
    logic [5:0] io_load_mm, io_load_ss, io_alarm_mm, io_mm, io_ss;
    logic       io_min_tick, io_hour_tick, io_day_tick, io_load_err, io_alarm;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    time_keeper dut (
        .clock(clock), .reset(reset), .io_sec_tick(io_sec_tick), .io_load(io_load),
        .io_load_hh(io_load_hh), .io_load_mm(io_load_mm), .io_load_ss(io_load_ss),
        .io_alarm_en(io_alarm_en), .io_alarm_hh(io_alarm_hh), .io_alarm_mm(io_alarm_mm),
        .io_alarm_ack(io_alarm_ack), .io_hh(io_hh), .io_mm(io_mm), .io_ss(io_ss),
        .io_min_tick(io_min_tick), .io_hour_tick(io_hour_tick), .io_day_tick(io_day_tick),
        .io_load_err(io_load_err), .io_alarm(io_alarm)
    );

    // flags = {min_tick, hour_tick, day_tick, load_err, alarm}
    typedef struct {
        logic       tick;
        logic       load;
        logic [4:0] lhh;
        logic [5:0] lmm;
        logic [5:0] lss;
        logic       en;
        logic [4:0] ahh;
        logic [5:0] amm;
        logic       ack;
        logic [4:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
        logic [4:0] flags;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic tick, input logic load, input int lhh,
                                input int lmm, input int lss, input logic en, input logic ack,
                                input int hh, input int mm, input int ss, input logic [4:0] flags);
        vec_t v;
        v.tick = tick; v.load = load;
        v.lhh = 5'(lhh); v.lmm = 6'(lmm); v.lss = 6'(lss);
        v.en = en; v.ahh = 5'd7; v.amm = 6'd30; v.ack = ack;
        v.hh = 5'(hh); v.mm = 6'(mm); v.ss = 6'(ss); v.flags = flags;
        return v;
    endfunction

    function automatic logic [21:0] outs();
        return {io_hh, io_mm, io_ss, io_min_tick, io_hour_tick, io_day_tick, io_load_err, io_alarm};
    endfunction

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got hh=%0d mm=%0d ss=%0d flags=%b, want hh=%0d mm=%0d ss=%0d flags=%b",
                     name, act[21:17], act[16:11], act[10:5], act[4:0],
                     exp[21:17], exp[16:11], exp[10:5], exp[4:0]);
        end
    endtask

    task automatic drive(input vec_t v);
        io_sec_tick = v.tick; io_load = v.load;
        io_load_hh = v.lhh; io_load_mm = v.lmm; io_load_ss = v.lss;
        io_alarm_en = v.en; io_alarm_hh = v.ahh; io_alarm_mm = v.amm; io_alarm_ack = v.ack;
    endtask

    task automatic idle_inputs();
        io_sec_tick = 1'b0; io_load = 1'b0; io_alarm_ack = 1'b0;
    endtask

    initial begin
        // tick load  hh  mm  ss  en ack   exp hh mm ss  flags
        vecs[0]  = mk(1'b0, 1'b1, 23, 59, 58, 1'b0, 1'b0, 23, 59, 58, 5'b00000);
        vecs[1]  = mk(1'b1, 1'b0,  0,  0,  0, 1'b0, 1'b0, 23, 59, 59, 5'b00000);
        vecs[2]  = mk(1'b1, 1'b0,  0,  0,  0, 1'b0, 1'b0,  0,  0,  0, 5'b11100);
        vecs[3]  = mk(1'b0, 1'b0,  0,  0,  0, 1'b0, 1'b0,  0,  0,  0, 5'b00000);
        vecs[4]  = mk(1'b1, 1'b1, 12, 34, 56, 1'b0, 1'b0, 12, 34, 56, 5'b00000);
        vecs[5]  = mk(1'b0, 1'b1, 24,  0,  0, 1'b0, 1'b0, 12, 34, 56, 5'b00010);
        vecs[6]  = mk(1'b0, 1'b0,  0,  0,  0, 1'b0, 1'b0, 12, 34, 56, 5'b00000);
        vecs[7]  = mk(1'b1, 1'b1, 24,  0,  0, 1'b0, 1'b0, 12, 34, 57, 5'b00010);
        vecs[8]  = mk(1'b0, 1'b1, 12, 60,  0, 1'b0, 1'b0, 12, 34, 57, 5'b00010);
        vecs[9]  = mk(1'b0, 1'b1, 12, 34, 60, 1'b0, 1'b0, 12, 34, 57, 5'b00010);
        vecs[10] = mk(1'b0, 1'b1,  7, 29, 59, 1'b1, 1'b0,  7, 29, 59, 5'b00000);
        vecs[11] = mk(1'b1, 1'b0,  0,  0,  0, 1'b1, 1'b0,  7, 30,  0, 5'b10001);
        vecs[12] = mk(1'b0, 1'b0,  0,  0,  0, 1'b1, 1'b0,  7, 30,  0, 5'b00001);
        vecs[13] = mk(1'b0, 1'b0,  0,  0,  0, 1'b1, 1'b1,  7, 30,  0, 5'b00000);
        vecs[14] = mk(1'b0, 1'b0,  0,  0,  0, 1'b1, 1'b1,  7, 30,  0, 5'b00000);
        vecs[15] = mk(1'b0, 1'b1,  7, 29, 59, 1'b1, 1'b0,  7, 29, 59, 5'b00000);
        vecs[16] = mk(1'b1, 1'b0,  0,  0,  0, 1'b1, 1'b0,  7, 30,  0, 5'b10001);
        vecs[17] = mk(1'b0, 1'b0,  0,  0,  0, 1'b0, 1'b0,  7, 30,  0, 5'b00000);
        vecs[18] = mk(1'b0, 1'b1,  7, 30,  0, 1'b1, 1'b0,  7, 30,  0, 5'b00000);
        vecs[19] = mk(1'b0, 1'b0,  0,  0,  0, 1'b1, 1'b0,  7, 30,  0, 5'b00000);
        vecs[20] = mk(1'b0, 1'b1,  7, 29, 59, 1'b1, 1'b0,  7, 29, 59, 5'b00000);
        vecs[21] = mk(1'b1, 1'b0,  0,  0,  0, 1'b1, 1'b1,  7, 30,  0, 5'b10001);
        vecs[22] = mk(1'b0, 1'b1,  0, 59, 59, 1'b1, 1'b1,  0, 59, 59, 5'b00000);
        vecs[23] = mk(1'b1, 1'b0,  0,  0,  0, 1'b1, 1'b0,  1,  0,  0, 5'b11001);
        vecs[24] = mk(1'b0, 1'b0,  0,  0,  0, 1'b1, 1'b1,  1,  0,  0, 5'b00000);
        vecs[25] = mk(1'b1, 1'b0,  0,  0,  0, 1'b1, 1'b0,  1,  0,  1, 5'b00000);
        vecs[26] = mk(1'b1, 1'b0,  0,  0,  0, 1'b1, 1'b0,  1,  0,  2, 5'b00000);
        // vectors 22-24 use alarm 01:00 to exercise the hour carry match
        vecs[22].ahh = 5'd1; vecs[22].amm = 6'd0;
        vecs[23].ahh = 5'd1; vecs[23].amm = 6'd0;
        vecs[24].ahh = 5'd1; vecs[24].amm = 6'd0;

        reset = 1'b0;
        idle_inputs();
        io_alarm_en = 1'b0; io_load_hh = 5'd0; io_load_mm = 6'd0; io_load_ss = 6'd0;
        io_alarm_hh = 5'd0; io_alarm_mm = 6'd0;
        repeat (2) @(posedge clock);
        #1 check("reset_state", outs(), 22'd0);
        @(negedge clock);
        reset = 1'b1;

        // Minute carry: 61 ticks from 00:00:00 -> 00:01:01, one min_tick at ss=0.
        begin
            int min_ticks = 0;
            int ss_at_tick = -1;
            for (int i = 0; i < 61; i++) begin
                io_sec_tick = 1'b1;
                @(posedge clock);
                #1;
                if (io_min_tick) begin
                    min_ticks++;
                    ss_at_tick = int'(io_ss);
                end
                @(negedge clock);
            end
            idle_inputs();
            check("count_61", outs(), {5'd0, 6'd1, 6'd1, 5'b00000});
            check("min_tick_count", 22'(min_ticks), 22'd1);
            check("min_tick_at_ss0", 22'(ss_at_tick), 22'd0);
        end

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            @(posedge clock);
            #1 check($sformatf("vec%0d", i), outs(),
                     {vecs[i].hh, vecs[i].mm, vecs[i].ss, vecs[i].flags});
            @(negedge clock);
        end
        idle_inputs();

        // Ringing alarm at 05:06:07, then an asynchronous reset between edges.
        io_alarm_en = 1'b1; io_alarm_hh = 5'd5; io_alarm_mm = 6'd7;
        io_load = 1'b1; io_load_hh = 5'd5; io_load_mm = 6'd6; io_load_ss = 6'd59;
        @(negedge clock);
        io_load = 1'b0; io_sec_tick = 1'b1;
        @(negedge clock);
        io_sec_tick = 1'b0; io_load = 1'b1; io_load_ss = 6'd7;
        @(negedge clock);
        io_load = 1'b0;
        check("pre_reset", outs(), {5'd5, 6'd6, 6'd7, 5'b00001});
        @(posedge clock);
        #2 reset = 1'b0;
        #1 check("async_reset", outs(), 22'd0);
        @(negedge clock);
        reset = 1'b1;
        io_sec_tick = 1'b1;
        @(posedge clock);
        #1 check("resume_after_reset", outs(), {5'd0, 6'd0, 6'd1, 5'b00000});
        @(negedge clock);
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
